// File: rtl/ad_ip_jesd204_tpl_adc_chan_mon.sv
// Receive channel for one JESD204 ADC converter: per-sample formatting plus a
// PN7 / PN15 / ramp monitor with debounced sync tracking and a saturating error count.
module ad_ip_jesd204_tpl_adc_chan_mon #(
   parameter int CONVERTER_RESOLUTION = 14,
   parameter int DATA_PATH_WIDTH      = 2,
   parameter int BITS_PER_SAMPLE      = 16,
   parameter int TWOS_COMPLEMENT      = 1,
   parameter int OOS_THRESHOLD        = 16,
   parameter int ERR_CNT_WIDTH        = 16
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               raw_valid,
   input  logic [CONVERTER_RESOLUTION*DATA_PATH_WIDTH-1:0]    raw_data,
   output logic                                               fmt_valid,
   output logic [BITS_PER_SAMPLE*DATA_PATH_WIDTH-1:0]         fmt_data,
   input  logic                                               dfmt_enable,
   input  logic                                               dfmt_type,
   input  logic                                               dfmt_sign_extend,
   input  logic [1:0]                                         mon_sel,
   input  logic                                               err_cnt_clr,
   output logic                                               pn_oos,
   output logic                                               pn_err,
   output logic [ERR_CNT_WIDTH-1:0]                           err_cnt
);

   localparam int N  = CONVERTER_RESOLUTION;
   localparam int D  = DATA_PATH_WIDTH;
   localparam int B  = BITS_PER_SAMPLE;
   localparam int HW = (N > 15) ? N : 15;
   localparam int RW = $clog2(OOS_THRESHOLD + 1);

   localparam logic [N-1:0]             MON_MASK = (TWOS_COMPLEMENT != 0) ?
                                                   {1'b1, {(N-1){1'b0}}} : {N{1'b0}};
   localparam logic [RW-1:0]            RUN_THR  = RW'(OOS_THRESHOLD);
   localparam logic [RW-1:0]            RUN_ONE  = RW'(1'b1);
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE  = ERR_CNT_WIDTH'(1'b1);
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = {ERR_CNT_WIDTH{1'b1}};

   typedef enum logic {
      ST_OOS  = 1'b0,
      ST_SYNC = 1'b1
   } mon_state_t;

   function automatic logic [B-1:0] fmt_sample(input logic [N-1:0] s,
                                               input logic en,
                                               input logic ty,
                                               input logic se);
      logic [N-1:0] sp;
      logic [B-1:0] r;
      sp = s;
      if (en && ty) begin
         sp[N-1] = ~s[N-1];
      end else begin
         sp[N-1] = s[N-1];
      end
      r        = {B{1'b0}};
      r[N-1:0] = sp;
      for (int j = N; j < B; j++) begin
         r[j] = en & se & sp[N-1];
      end
      return r;
   endfunction

   // History keeps the most recent bit in bit 0, so PN taps are plain indices.
   function automatic logic [HW-1:0] hist_push(input logic [HW-1:0] h,
                                               input logic [N-1:0] s);
      logic [HW-1:0] r;
      r = h;
      for (int i = N - 1; i >= 0; i--) begin
         r = {r[HW-2:0], s[i]};
      end
      return r;
   endfunction

   function automatic logic [N-1:0] pn_next(input logic [1:0] mode,
                                            input logic [HW-1:0] hist);
      logic [HW-1:0] h;
      logic [N-1:0]  r;
      logic          b;
      h = hist;
      r = {N{1'b0}};
      b = 1'b0;
      case (mode)
         2'd3: r = hist[N-1:0] + N'(1'b1);
         default: begin
            for (int i = N - 1; i >= 0; i--) begin
               b    = (mode == 2'd1) ? (h[5] ^ h[6]) : (h[13] ^ h[14]);
               r[i] = b;
               h    = {h[HW-2:0], b};
            end
         end
      endcase
      return r;
   endfunction

   logic                     fmt_valid_q, fmt_valid_d;
   logic [B*D-1:0]           fmt_data_q, fmt_data_d;
   logic [1:0]               mon_sel_q, mon_sel_d;
   logic                     seed_pend_q, seed_pend_d;
   logic [HW-1:0]            seed_q, seed_d;
   logic                     cmp_vld_q, cmp_vld_d;
   logic [N*D-1:0]           in_q, in_d;
   logic [N*D-1:0]           exp_q, exp_d;
   mon_state_t               state_q, state_d;
   logic [RW-1:0]            run_q, run_d;
   logic                     pn_err_q, pn_err_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   logic                     mode_chg_s;
   logic                     seed_only_s;
   logic                     use_rx_s;
   logic                     match_s;
   logic [RW-1:0]            run_inc_s;
   logic [HW-1:0]            hist_s;
   logic [N-1:0]             rx_s;
   logic [N-1:0]             ex_s;

   // Format path: one-cycle latency, data held across invalid beats.
   always_comb begin
      fmt_valid_d = raw_valid;
      fmt_data_d  = fmt_data_q;
      if (raw_valid) begin
         for (int k = 0; k < D; k++) begin
            fmt_data_d[k*B +: B] = fmt_sample(raw_data[k*N +: N], dfmt_enable,
                                              dfmt_type, dfmt_sign_extend);
         end
      end else begin
         fmt_data_d = fmt_data_q;
      end
   end

   // Monitor stage 1: capture samples and their expectations; a beat right after a mode change only seeds.
   always_comb begin
      mode_chg_s  = (mon_sel != mon_sel_q) || (mon_sel == 2'd0);
      seed_only_s = seed_pend_q || mode_chg_s;
      use_rx_s    = seed_only_s || (state_q == ST_OOS);
      mon_sel_d   = mon_sel;
      hist_s      = seed_q;
      rx_s        = {N{1'b0}};
      ex_s        = {N{1'b0}};
      in_d        = in_q;
      exp_d       = exp_q;
      seed_d      = seed_q;
      cmp_vld_d   = 1'b0;
      seed_pend_d = seed_pend_q;
      if (raw_valid) begin
         for (int k = 0; k < D; k++) begin
            rx_s               = raw_data[k*N +: N] ^ MON_MASK;
            ex_s               = pn_next(mon_sel, hist_s);
            in_d[k*N +: N]     = rx_s;
            exp_d[k*N +: N]    = ex_s;
            if (use_rx_s) begin
               hist_s = hist_push(hist_s, rx_s);
            end else begin
               hist_s = hist_push(hist_s, ex_s);
            end
         end
         seed_d      = hist_s;
         cmp_vld_d   = ~seed_only_s;
         seed_pend_d = 1'b0;
      end else if (mode_chg_s) begin
         seed_pend_d = 1'b1;
      end else begin
         seed_pend_d = seed_pend_q;
      end
   end

   // Monitor stage 2: compare, debounce sync state, count errors.
   always_comb begin
      match_s   = (in_q == exp_q);
      run_inc_s = run_q + RUN_ONE;
      state_d   = state_q;
      run_d     = run_q;
      pn_err_d  = 1'b0;
      if (mode_chg_s) begin
         state_d = ST_OOS;
         run_d   = {RW{1'b0}};
      end else if (cmp_vld_q) begin
         case (state_q)
            ST_OOS: begin
               if (!match_s) begin
                  run_d = {RW{1'b0}};
               end else if (run_inc_s == RUN_THR) begin
                  state_d = ST_SYNC;
                  run_d   = {RW{1'b0}};
               end else begin
                  run_d = run_inc_s;
               end
            end
            ST_SYNC: begin
               if (match_s) begin
                  run_d = {RW{1'b0}};
               end else if (run_inc_s == RUN_THR) begin
                  pn_err_d = 1'b1;
                  state_d  = ST_OOS;
                  run_d    = {RW{1'b0}};
               end else begin
                  pn_err_d = 1'b1;
                  run_d    = run_inc_s;
               end
            end
            default: begin
               state_d = ST_OOS;
               run_d   = {RW{1'b0}};
            end
         endcase
      end else begin
         state_d = state_q;
      end

      if (err_cnt_clr) begin
         err_cnt_d = {ERR_CNT_WIDTH{1'b0}};
      end else if (pn_err_q && (err_cnt_q != ERR_MAX)) begin
         err_cnt_d = err_cnt_q + ERR_ONE;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // All state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fmt_valid_q <= 1'b0;
         fmt_data_q  <= {(B*D){1'b0}};
         mon_sel_q   <= 2'd0;
         seed_pend_q <= 1'b1;
         seed_q      <= {HW{1'b0}};
         cmp_vld_q   <= 1'b0;
         in_q        <= {(N*D){1'b0}};
         exp_q       <= {(N*D){1'b0}};
         state_q     <= ST_OOS;
         run_q       <= {RW{1'b0}};
         pn_err_q    <= 1'b0;
         err_cnt_q   <= {ERR_CNT_WIDTH{1'b0}};
      end else begin
         fmt_valid_q <= fmt_valid_d;
         fmt_data_q  <= fmt_data_d;
         mon_sel_q   <= mon_sel_d;
         seed_pend_q <= seed_pend_d;
         seed_q      <= seed_d;
         cmp_vld_q   <= cmp_vld_d;
         in_q        <= in_d;
         exp_q       <= exp_d;
         state_q     <= state_d;
         run_q       <= run_d;
         pn_err_q    <= pn_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign fmt_valid = fmt_valid_q;
   assign fmt_data  = fmt_data_q;
   assign pn_oos    = (state_q == ST_OOS);
   assign pn_err    = pn_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_chan_mon.sv
// Directed bench for ad_ip_jesd204_tpl_adc_chan_mon: formatting, ramp/PN lock,
// error pulses, saturation, clear priority, mode switch and asynchronous reset.
module tb_ad_ip_jesd204_tpl_adc_chan_mon;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        raw_valid;
   logic [27:0] raw_data;
   logic        fmt_valid;
   logic [31:0] fmt_data;
   logic        dfmt_enable;
   logic        dfmt_type;
   logic        dfmt_sign_extend;
   logic [1:0]  mon_sel;
   logic        err_cnt_clr;
   logic        pn_oos;
   logic        pn_err;
   logic [3:0]  err_cnt;

   int n_checks   = 0;
   int n_errors   = 0;
   int err_pulses = 0;
   int base       = 0;
   int idx7       = 0;
   int idx15      = 0;

   logic        bits7  [0:3583];
   logic        bits15 [0:3583];
   logic [13:0] pn7_s  [0:255];
   logic [13:0] pn15_s [0:255];

   ad_ip_jesd204_tpl_adc_chan_mon #(
      .CONVERTER_RESOLUTION (14),
      .DATA_PATH_WIDTH      (2),
      .BITS_PER_SAMPLE      (16),
      .TWOS_COMPLEMENT      (0),
      .OOS_THRESHOLD        (4),
      .ERR_CNT_WIDTH        (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .raw_valid        (raw_valid),
      .raw_data         (raw_data),
      .fmt_valid        (fmt_valid),
      .fmt_data         (fmt_data),
      .dfmt_enable      (dfmt_enable),
      .dfmt_type        (dfmt_type),
      .dfmt_sign_extend (dfmt_sign_extend),
      .mon_sel          (mon_sel),
      .err_cnt_clr      (err_cnt_clr),
      .pn_oos           (pn_oos),
      .pn_err           (pn_err),
      .err_cnt          (err_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pn_err === 1'b1) err_pulses <= err_pulses + 1;
   end

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [13:0] s1, input logic [13:0] s0);
      raw_valid = 1'b1;
      raw_data  = {s1, s0};
      tick();
   endtask

   task automatic idle(input int n);
      raw_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send_pn(input int poly, input logic corrupt);
      logic [13:0] s0;
      logic [13:0] s1;
      if (poly == 7) begin
         s0 = pn7_s[idx7];
         s1 = pn7_s[idx7+1];
         idx7 += 2;
      end else begin
         s0 = pn15_s[idx15];
         s1 = pn15_s[idx15+1];
         idx15 += 2;
      end
      if (corrupt) s0 = s0 ^ 14'h0001;
      send_beat(s1, s0);
   endtask

   initial begin
      // Reference PN bit streams straight from the recurrences, chopped MSB-first.
      for (int n = 0; n < 3584; n++) begin
         if (n < 7)  bits7[n]  = 1'b1; else bits7[n]  = bits7[n-6]   ^ bits7[n-7];
         if (n < 15) bits15[n] = 1'b1; else bits15[n] = bits15[n-14] ^ bits15[n-15];
      end
      for (int j = 0; j < 256; j++) begin
         for (int b = 0; b < 14; b++) begin
            pn7_s[j][13-b]  = bits7[14*j+b];
            pn15_s[j][13-b] = bits15[14*j+b];
         end
      end

      raw_valid        = 1'b0;
      raw_data         = 28'h0;
      dfmt_enable      = 1'b1;
      dfmt_type        = 1'b1;
      dfmt_sign_extend = 1'b1;
      mon_sel          = 2'd0;
      err_cnt_clr      = 1'b0;
      #12;
      check_value("rst_fmt_valid", {31'h0, fmt_valid}, 32'h0);
      check_value("rst_fmt_data", fmt_data, 32'h0);
      check_value("rst_pn_oos", {31'h0, pn_oos}, 32'h1);
      check_value("rst_pn_err", {31'h0, pn_err}, 32'h0);
      check_value("rst_err_cnt", {28'h0, err_cnt}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      send_beat(14'h2000, 14'h0000);
      check_value("fmt_valid_hi", {31'h0, fmt_valid}, 32'h1);
      check_value("fmt_0000_2000", fmt_data, 32'h0000E000);
      send_beat(14'h0000, 14'h3FFF);
      check_value("fmt_3fff_0000", fmt_data, 32'hE0001FFF);
      raw_data = 28'h0;
      idle(1);
      check_value("fmt_valid_lo", {31'h0, fmt_valid}, 32'h0);
      check_value("fmt_hold", fmt_data, 32'hE0001FFF);
      dfmt_enable = 1'b0;
      send_beat(14'h3FFF, 14'h2000);
      check_value("fmt_disabled", fmt_data, 32'h3FFF2000);
      dfmt_enable = 1'b1;
      dfmt_type   = 1'b0;
      send_beat(14'h1FFF, 14'h2000);
      check_value("fmt_sext_only", fmt_data, 32'h1FFFE000);
      idle(1);

      // Ramp: first beat seeds, four more reach the threshold.
      base    = err_pulses;
      mon_sel = 2'd3;
      for (int i = 0; i < 5; i++) begin
         send_beat(14'(2*i+1), 14'(2*i));
      end
      check_value("ramp_oos_before", {31'h0, pn_oos}, 32'h1);
      idle(1);
      check_value("ramp_lock", {31'h0, pn_oos}, 32'h0);
      check_value("ramp_no_err", err_pulses - base, 32'h0);
      check_value("ramp_err_cnt", {28'h0, err_cnt}, 32'h0);

      mon_sel = 2'd2;
      repeat (5) send_pn(15, 1'b0);
      idle(1);
      check_value("pn15_lock", {31'h0, pn_oos}, 32'h0);

      base = err_pulses;
      send_pn(15, 1'b1);
      send_pn(15, 1'b0);
      check_value("single_err_pulse", {31'h0, pn_err}, 32'h1);
      send_pn(15, 1'b0);
      check_value("single_err_once", {31'h0, pn_err}, 32'h0);
      idle(1);
      check_value("single_err_cnt", {28'h0, err_cnt}, 32'h1);
      check_value("single_err_sync", {31'h0, pn_oos}, 32'h0);
      check_value("single_err_pulses", err_pulses - base, 32'h1);

      base = err_pulses;
      idle(10);
      check_value("gap_sync", {31'h0, pn_oos}, 32'h0);
      send_pn(15, 1'b0);
      send_pn(15, 1'b0);
      idle(2);
      check_value("gap_sync_after", {31'h0, pn_oos}, 32'h0);
      check_value("gap_no_err", err_pulses - base, 32'h0);

      base = err_pulses;
      repeat (20) begin
         send_pn(15, 1'b1);
         send_pn(15, 1'b0);
      end
      idle(2);
      check_value("sat_err_cnt", {28'h0, err_cnt}, 32'hF);
      check_value("sat_pulses", err_pulses - base, 32'd20);
      check_value("sat_sync", {31'h0, pn_oos}, 32'h0);

      send_pn(15, 1'b1);
      send_pn(15, 1'b0);
      check_value("clr_err_pulse", {31'h0, pn_err}, 32'h1);
      err_cnt_clr = 1'b1;
      send_pn(15, 1'b0);
      err_cnt_clr = 1'b0;
      check_value("clr_wins", {28'h0, err_cnt}, 32'h0);
      idle(1);
      check_value("clr_no_late_inc", {28'h0, err_cnt}, 32'h0);

      // Four corrupted beats drop sync; four clean beats regain it.
      base = err_pulses;
      repeat (4) send_pn(15, 1'b1);
      send_pn(15, 1'b0);
      check_value("loss_oos", {31'h0, pn_oos}, 32'h1);
      repeat (3) send_pn(15, 1'b0);
      check_value("realign_pending", {31'h0, pn_oos}, 32'h1);
      idle(1);
      check_value("realign_lock", {31'h0, pn_oos}, 32'h0);
      check_value("loss_pulses", err_pulses - base, 32'd4);
      check_value("loss_err_cnt", {28'h0, err_cnt}, 32'h4);

      base    = err_pulses;
      mon_sel = 2'd1;
      idle(1);
      check_value("mode_switch_oos", {31'h0, pn_oos}, 32'h1);
      repeat (5) send_pn(7, 1'b0);
      idle(1);
      check_value("pn7_lock", {31'h0, pn_oos}, 32'h0);
      check_value("pn7_no_err", err_pulses - base, 32'h0);

      send_pn(7, 1'b0);
      check_value("pre_rst_fmt_valid", {31'h0, fmt_valid}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check_value("async_rst_pn_oos", {31'h0, pn_oos}, 32'h1);
      check_value("async_rst_fmt_valid", {31'h0, fmt_valid}, 32'h0);
      check_value("async_rst_err_cnt", {28'h0, err_cnt}, 32'h0);
      check_value("async_rst_fmt_data", fmt_data, 32'h0);
      raw_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();
      repeat (4) send_pn(7, 1'b0);
      idle(2);
      check_value("rst_resume_pending", {31'h0, pn_oos}, 32'h1);
      send_pn(7, 1'b0);
      idle(2);
      check_value("rst_resume_lock", {31'h0, pn_oos}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
